// File: rtl/tb_clk_mgr_pkg.sv
// Shared definitions for the simulation clock manager: register offsets,
// regbus payload types and the bus FSM states.
package tb_clk_mgr_pkg;

    localparam int unsigned DivWidth = 8;

    localparam logic [7:0] DivLimit   = 8'h40;
    localparam logic [7:0] StatusOff  = 8'h40;
    localparam logic [7:0] ScratchOff = 8'h44;
    localparam logic [7:0] WcountOff  = 8'h48;

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_a48_d32_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_a48_d32_rsp_t;

endpackage

// File: rtl/tb_clk_mgr_lock_cnt.sv
// Per-domain lock model: a reload counter that reports locked once it has
// run down to zero with the domain enabled.
module tb_clk_mgr_lock_cnt #(
    parameter int unsigned LockCycles = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load,
    input  logic en,
    output logic locked
);

    localparam logic [15:0] Init = 16'(LockCycles);

    logic [15:0] cnt;

    // A disabled domain freezes its count and never reports lock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= Init;
            locked <= 1'b0;
        end else if (load) begin
            cnt    <= Init;
            locked <= 1'b0;
        end else if (!en) begin
            locked <= 1'b0;
        end else if (cnt != 16'd0) begin
            cnt    <= cnt - 16'd1;
            locked <= (cnt == 16'd1);
        end else begin
            locked <= 1'b1;
        end
    end

endmodule

// File: rtl/tb_clk_mgr.sv
// Regbus slave modelling the clock manager: per-domain divider/enable
// registers, lock counters, a scratch register and a write counter.
module tb_clk_mgr
    import tb_clk_mgr_pkg::*;
#(
    parameter int unsigned NumDomains = 4,
    parameter int unsigned LockCycles = 16,
    parameter logic [47:0] BaseAddr   = 48'h0,
    parameter type         req_t      = reg_a48_d32_req_t,
    parameter type         rsp_t      = reg_a48_d32_rsp_t
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  req_t                                 req_i,
    output rsp_t                                 rsp_o,
    output logic [NumDomains-1:0][DivWidth-1:0]  div_o,
    output logic [NumDomains-1:0]                en_o,
    output logic [NumDomains-1:0]                locked_o
);

    // Handshake: the requester holds valid and payload stable until ready;
    // ready is a single-cycle pulse in RESP, with rdata/error valid only then.
    state_e          state_q, state_d;
    logic [47:0]     addr_q;
    logic            write_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic [31:0]     scratch_q;
    logic [31:0]     wcount_q;

    logic [47:0]     off_full;
    logic [7:0]      off;
    logic [5:0]      word;
    logic            in_range, aligned;
    logic            is_div, is_status, is_scratch, is_wcount;
    logic            error, commit;
    logic [31:0]     rdata;
    logic [NumDomains-1:0] dom_sel, load;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i.valid) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_i.valid) begin
                addr_q  <= req_i.addr;
                write_q <= req_i.write;
                wdata_q <= req_i.wdata;
                wstrb_q <= req_i.wstrb;
            end
        end
    end

    assign off_full = addr_q - BaseAddr;
    assign off      = off_full[7:0];
    assign word     = off[7:2];
    assign in_range = (addr_q >= BaseAddr) && (off_full[47:8] == '0);
    assign aligned  = (addr_q[1:0] == 2'b00);

    always_comb begin
        dom_sel = '0;
        for (int i = 0; i < NumDomains; i++) begin
            dom_sel[i] = in_range && aligned && (off < DivLimit) && (word == 6'(i));
        end
    end

    assign is_div     = |dom_sel;
    assign is_status  = in_range && (off == StatusOff);
    assign is_scratch = in_range && (off == ScratchOff);
    assign is_wcount  = in_range && (off == WcountOff);
    assign error      = !(is_div || is_scratch || ((is_status || is_wcount) && !write_q));
    assign commit     = (state_q == RESP) && write_q && !error;

    always_comb begin
        rdata = '0;
        if (!error) begin
            if (is_status)       rdata[NumDomains-1:0] = locked_o;
            else if (is_scratch) rdata = scratch_q;
            else if (is_wcount)  rdata = wcount_q;
            for (int i = 0; i < NumDomains; i++) begin
                if (dom_sel[i]) rdata = {en_o[i], 23'b0, div_o[i]};
            end
        end
    end

    always_comb begin
        rsp_o = '0;
        if (state_q == RESP) begin
            rsp_o.ready = 1'b1;
            rsp_o.error = error;
            rsp_o.rdata = rdata;
        end
    end

    // A zero divider would stall the domain, so it is stored as 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_o     <= {NumDomains{DivWidth'(1)}};
            en_o      <= '1;
            scratch_q <= '0;
            wcount_q  <= '0;
        end else if (commit) begin
            wcount_q <= wcount_q + 32'd1;
            for (int i = 0; i < NumDomains; i++) begin
                if (dom_sel[i]) begin
                    if (wstrb_q[0]) div_o[i] <= (wdata_q[7:0] == 8'd0) ? 8'd1 : wdata_q[7:0];
                    if (wstrb_q[3]) en_o[i]  <= wdata_q[31];
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (is_scratch && wstrb_q[b]) scratch_q[8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    for (genvar g = 0; g < NumDomains; g++) begin : g_dom
        assign load[g] = commit && dom_sel[g] && (wstrb_q[0] || wstrb_q[3]);

        tb_clk_mgr_lock_cnt #(
            .LockCycles(LockCycles)
        ) u_lock (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .load  (load[g]),
            .en    (en_o[g]),
            .locked(locked_o[g])
        );
    end

endmodule
